l1_l2_request_arbiter: RTL and testbench
========================================

Name: l1_l2_request_arbiter

Overview:
- Shares the single L2 request/response channel between the split L1 instruction cache (read misses) and the L1 data cache (read misses, write-through and write-back traffic).
- Round-robin arbitration, one outstanding L2 transaction at a time, completion pulse routed back to the originating cache.
- Forwards L2 inclusivity evictions to the data cache and keeps per-requester grant statistics.

Parameters:
ADDRESS_WIDTH, 32, width of all address buses
CNT_WIDTH, 16, width of saturating grant counters

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
i_req_valid  input  1  I-cache read-miss request
i_req_addr  input  ADDRESS_WIDTH  I-cache request address
i_req_ready  output  1  I request accepted this cycle
d_req_valid  input  1  D-cache request
d_req_write  input  1  1 = write (through/back), 0 = read miss
d_req_addr  input  ADDRESS_WIDTH  D-cache request address
d_req_ready  output  1  D request accepted this cycle
l2_req_valid  output  1  request to L2
l2_req_ready  input  1  L2 accepts request
l2_req_write  output  1  latched write flag
l2_req_addr  output  ADDRESS_WIDTH  latched address
l2_req_src  output  1  0 = I, 1 = D
l2_resp_valid  input  1  L2 read data returned (one-cycle pulse)
i_resp_valid  output  1  completion pulse to I-cache
d_resp_valid  output  1  completion pulse to D-cache
l2_evict_valid  input  1  L2 eviction notice
l2_evict_addr  input  ADDRESS_WIDTH  evicted line address
d_evict_valid  output  1  eviction forwarded to D-cache
d_evict_addr  output  ADDRESS_WIDTH  forwarded address
i_grant_count  output  CNT_WIDTH  I grants since reset
d_grant_count  output  CNT_WIDTH  D grants since reset
busy  output  1  FSM not in IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; last_src = 1 (D), so the I requester wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, requester selection:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not equal to last_src.
  - x_req_ready is combinational and high only in IDLE for the granted requester. Acceptance = valid & ready.
- IDLE, on acceptance:
  - Latch addr, write (I is always 0) and src; update last_src.
  - Increment that requester's grant counter, saturating at all-ones.
  - Next state ISSUE.
- Requesters hold valid and addr stable until ready. Dropping valid before ready is legal; no grant occurs.
- ISSUE:
  - l2_req_valid = 1 with latched write/addr/src, held stable until l2_req_ready.
  - On l2_req_ready: write goes to RESP, read goes to WAIT.
- WAIT: on l2_resp_valid go to RESP. An l2_resp_valid arriving in any other state is ignored.
- RESP: one-cycle pulse on i_resp_valid or d_resp_valid, selected by latched src; next state IDLE. No new grant is issued in RESP.
- Minimum read latency: accept at T, l2_req_valid at T+1 (ready same cycle), WAIT at T+2 (resp same cycle), resp pulse at T+3, next grant possible at T+4.
- Minimum write latency: accept at T, issue at T+1, resp pulse at T+2.
- Eviction path:
  - Independent of the FSM: d_evict_valid / d_evict_addr are l2_evict_valid / l2_evict_addr registered by exactly one cycle, every cycle, including during any FSM state.
  - An eviction matching a pending D read line (addr[31:6]) is still forwarded; the D-cache resolves ordering.
- busy = (state != IDLE).
- rst asserted mid-transaction: the transaction is abandoned, no resp pulse, counters cleared, state IDLE on the next edge.
- A requester asserting valid while another transaction is in flight waits. Fairness: with both requesters continuously valid, grants alternate I, D, I, D.

Test Plan:
- Single I read: i_req_valid=1, addr=0x1234_5640 at cycle 1, l2_req_ready=1, l2_resp_valid at cycle 4 -> i_req_ready at cycle 1; l2_req_valid with addr 0x12345640, src=0, write=0 at cycle 2; i_resp_valid pulse at cycle 5; i_grant_count=1.
- Simultaneous requests after reset: I addr 0xA000_0000 and D read 0xB000_0040 both valid, L2 always ready, resp 1 cycle after WAIT entry -> I granted first, D second; l2_req_src sequence 0,1; counts 1/1.
- D write: d_req_write=1, addr=0x0000_0FC0, l2_req_ready held 0 for 3 cycles -> l2_req_valid stays 1 with stable addr/write=1 for 4 cycles; d_resp_valid pulses the cycle after the ready handshake; no l2_resp_valid needed.
- Eviction during WAIT: l2_evict_valid pulse with addr 0x1234_5640 while a D read is outstanding -> d_evict_valid/addr appear exactly one cycle later; FSM is unaffected and d_resp_valid still pulses after l2_resp_valid.
- Reset mid-operation: rst=1 in WAIT -> next cycle busy=0, no resp pulse, counts=0; a stray l2_resp_valid afterwards produces no resp pulse.
- Counter saturation with CNT_WIDTH=2: 5 I reads -> i_grant_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/l1_l2_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// l1_l2_request_arbiter_if : L1 I/D request, L2 channel and eviction bundle
// Revision: 1.0
// ============================================================================
interface l1_l2_request_arbiter_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int CNT_WIDTH     = 16
);
   logic                     i_req_valid;
   logic [ADDRESS_WIDTH-1:0] i_req_addr;
   logic                     i_req_ready;
   logic                     d_req_valid;
   logic                     d_req_write;
   logic [ADDRESS_WIDTH-1:0] d_req_addr;
   logic                     d_req_ready;
   logic                     l2_req_valid;
   logic                     l2_req_ready;
   logic                     l2_req_write;
   logic [ADDRESS_WIDTH-1:0] l2_req_addr;
   logic                     l2_req_src;
   logic                     l2_resp_valid;
   logic                     i_resp_valid;
   logic                     d_resp_valid;
   logic                     l2_evict_valid;
   logic [ADDRESS_WIDTH-1:0] l2_evict_addr;
   logic                     d_evict_valid;
   logic [ADDRESS_WIDTH-1:0] d_evict_addr;
   logic [CNT_WIDTH-1:0]     i_grant_count;
   logic [CNT_WIDTH-1:0]     d_grant_count;
   logic                     busy;

   modport slave (
      input  i_req_valid, i_req_addr, d_req_valid, d_req_write, d_req_addr,
             l2_req_ready, l2_resp_valid, l2_evict_valid, l2_evict_addr,
      output i_req_ready, d_req_ready, l2_req_valid, l2_req_write, l2_req_addr,
             l2_req_src, i_resp_valid, d_resp_valid, d_evict_valid, d_evict_addr,
             i_grant_count, d_grant_count, busy
   );

   modport master (
      output i_req_valid, i_req_addr, d_req_valid, d_req_write, d_req_addr,
             l2_req_ready, l2_resp_valid, l2_evict_valid, l2_evict_addr,
      input  i_req_ready, d_req_ready, l2_req_valid, l2_req_write, l2_req_addr,
             l2_req_src, i_resp_valid, d_resp_valid, d_evict_valid, d_evict_addr,
             i_grant_count, d_grant_count, busy
   );
endinterface
`default_nettype wire

// File: rtl/l1_l2_request_arbiter.sv
`default_nettype none
// ============================================================================
// l1_l2_request_arbiter : round-robin I/D arbiter onto a single-outstanding L2
// Revision: 1.0
// ============================================================================
module l1_l2_request_arbiter #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int CNT_WIDTH     = 16
) (
   input  wire logic              clk,
   input  wire logic              rst,
   l1_l2_request_arbiter_if.slave bus
);
   localparam logic [1:0]           c_IDLE    = 2'd0;
   localparam logic [1:0]           c_ISSUE   = 2'd1;
   localparam logic [1:0]           c_WAIT    = 2'd2;
   localparam logic [1:0]           c_RESP    = 2'd3;
   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]               state_q, state_d;
   logic                     last_src_q, last_src_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     write_q, write_d;
   logic                     src_q, src_d;
   logic [CNT_WIDTH-1:0]     i_cnt_q, i_cnt_d;
   logic [CNT_WIDTH-1:0]     d_cnt_q, d_cnt_d;
   logic                     evict_valid_q, evict_valid_d;
   logic [ADDRESS_WIDTH-1:0] evict_addr_q, evict_addr_d;

   logic w_idle;
   logic w_grant_i;
   logic w_grant_d;
   logic w_accept_i;
   logic w_accept_d;

   // On a tie the requester that did not win last time is chosen
   assign w_idle     = (state_q == c_IDLE) && !rst;
   assign w_grant_i  = bus.i_req_valid && (!bus.d_req_valid || last_src_q);
   assign w_grant_d  = bus.d_req_valid && (!bus.i_req_valid || !last_src_q);
   assign w_accept_i = w_idle && w_grant_i;
   assign w_accept_d = w_idle && w_grant_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= c_IDLE;
         last_src_q    <= 1'b1;
         addr_q        <= '0;
         write_q       <= 1'b0;
         src_q         <= 1'b0;
         i_cnt_q       <= '0;
         d_cnt_q       <= '0;
         evict_valid_q <= 1'b0;
         evict_addr_q  <= '0;
      end else begin
         state_q       <= state_d;
         last_src_q    <= last_src_d;
         addr_q        <= addr_d;
         write_q       <= write_d;
         src_q         <= src_d;
         i_cnt_q       <= i_cnt_d;
         d_cnt_q       <= d_cnt_d;
         evict_valid_q <= evict_valid_d;
         evict_addr_q  <= evict_addr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      last_src_d    = last_src_q;
      addr_d        = addr_q;
      write_d       = write_q;
      src_d         = src_q;
      i_cnt_d       = i_cnt_q;
      d_cnt_d       = d_cnt_q;
      evict_valid_d = bus.l2_evict_valid;
      evict_addr_d  = bus.l2_evict_addr;
      case (state_q)
         c_IDLE: begin
            if (w_accept_i) begin
               addr_d     = bus.i_req_addr;
               write_d    = 1'b0;
               src_d      = 1'b0;
               last_src_d = 1'b0;
               if (i_cnt_q != c_CNT_MAX) i_cnt_d = i_cnt_q + c_CNT_ONE;
               state_d    = c_ISSUE;
            end else if (w_accept_d) begin
               addr_d     = bus.d_req_addr;
               write_d    = bus.d_req_write;
               src_d      = 1'b1;
               last_src_d = 1'b1;
               if (d_cnt_q != c_CNT_MAX) d_cnt_d = d_cnt_q + c_CNT_ONE;
               state_d    = c_ISSUE;
            end
         end
         c_ISSUE: begin
            // Writes carry no returned data, so they complete on the handshake
            if (bus.l2_req_ready) state_d = write_q ? c_RESP : c_WAIT;
         end
         c_WAIT: begin
            if (bus.l2_resp_valid) state_d = c_RESP;
         end
         c_RESP: begin
            state_d = c_IDLE;
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.i_req_ready   = w_accept_i;
      bus.d_req_ready   = w_accept_d;
      bus.l2_req_valid  = (state_q == c_ISSUE);
      bus.l2_req_write  = write_q;
      bus.l2_req_addr   = addr_q;
      bus.l2_req_src    = src_q;
      bus.i_resp_valid  = (state_q == c_RESP) && !src_q;
      bus.d_resp_valid  = (state_q == c_RESP) && src_q;
      bus.d_evict_valid = evict_valid_q;
      bus.d_evict_addr  = evict_addr_q;
      bus.i_grant_count = i_cnt_q;
      bus.d_grant_count = d_cnt_q;
      bus.busy          = (state_q != c_IDLE);
   end
endmodule
`default_nettype wire

// File: tb/tb_l1_l2_request_arbiter.sv
`default_nettype none
// ============================================================================
// tb_l1_l2_request_arbiter : directed bench with a transaction-level reference
// Revision: 1.0
// ============================================================================
module tb_l1_l2_request_arbiter;
   localparam int AW   = 32;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   chk_en   = 0;

   l1_l2_request_arbiter_if #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   l1_l2_request_arbiter #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one transaction record walking issue -> (data) -> done
   bit            m_busy = 0, m_sent = 0, m_done = 0, m_last = 1;
   bit            m_src = 0, m_write = 0;
   logic [AW-1:0] m_addr = '0;
   int            m_icnt = 0, m_dcnt = 0;
   bit            m_ev_v = 0;
   logic [AW-1:0] m_ev_a = '0;

   function automatic int pick(input bit iv, input bit dv, input bit last);
      if (iv && dv) return last ? 0 : 1;
      if (iv) return 0;
      if (dv) return 1;
      return -1;
   endfunction

   always @(posedge clk) begin : model
      int w;
      w = pick(bus.i_req_valid, bus.d_req_valid, m_last);
      if (rst) begin
         m_busy <= 0; m_sent <= 0; m_done <= 0; m_last <= 1;
         m_src <= 0; m_write <= 0; m_addr <= '0;
         m_icnt <= 0; m_dcnt <= 0; m_ev_v <= 0; m_ev_a <= '0;
      end else begin
         m_ev_v <= bus.l2_evict_valid;
         m_ev_a <= bus.l2_evict_addr;
         if (!m_busy) begin
            if (w == 0) begin
               m_busy <= 1; m_src <= 0; m_write <= 0; m_addr <= bus.i_req_addr; m_last <= 0;
               m_icnt <= (m_icnt < CMAX) ? m_icnt + 1 : m_icnt;
            end else if (w == 1) begin
               m_busy <= 1; m_src <= 1; m_write <= bus.d_req_write; m_addr <= bus.d_req_addr; m_last <= 1;
               m_dcnt <= (m_dcnt < CMAX) ? m_dcnt + 1 : m_dcnt;
            end
         end else if (!m_sent) begin
            if (bus.l2_req_ready) begin
               m_sent <= 1;
               m_done <= m_write;
            end
         end else if (!m_done) begin
            if (bus.l2_resp_valid) m_done <= 1;
         end else begin
            m_busy <= 0; m_sent <= 0; m_done <= 0;
         end
      end
   end

   always @(negedge clk) begin : compare
      int  w;
      bit  e_l2v;
      if (chk_en) begin
         w     = pick(bus.i_req_valid, bus.d_req_valid, m_last);
         e_l2v = m_busy && !m_sent;
         chk("m_i_req_ready", bus.i_req_ready, !rst && !m_busy && w == 0);
         chk("m_d_req_ready", bus.d_req_ready, !rst && !m_busy && w == 1);
         chk("m_l2_req_valid", bus.l2_req_valid, e_l2v);
         if (e_l2v) begin
            chk("m_l2_req_addr", bus.l2_req_addr, m_addr);
            chk("m_l2_req_write", bus.l2_req_write, m_write);
            chk("m_l2_req_src", bus.l2_req_src, m_src);
         end
         chk("m_i_resp_valid", bus.i_resp_valid, m_busy && m_done && !m_src);
         chk("m_d_resp_valid", bus.d_resp_valid, m_busy && m_done && m_src);
         chk("m_busy", bus.busy, m_busy);
         chk("m_d_evict_valid", bus.d_evict_valid, m_ev_v);
         if (m_ev_v) chk("m_d_evict_addr", bus.d_evict_addr, m_ev_a);
         chk("m_i_grant_count", bus.i_grant_count, m_icnt);
         chk("m_d_grant_count", bus.d_grant_count, m_dcnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1;
      bus.i_req_valid = 0; bus.i_req_addr = '0;
      bus.d_req_valid = 0; bus.d_req_write = 0; bus.d_req_addr = '0;
      bus.l2_req_ready = 0; bus.l2_resp_valid = 0;
      bus.l2_evict_valid = 0; bus.l2_evict_addr = '0;
      step();
      step();
      rst = 0;
   endtask

   int src_q[$];
   int sat_exp[5] = '{1, 2, 3, 3, 3};

   initial begin
      rst = 1;
      do_reset();
      chk_en = 1;
      at_neg();
      chk("reset_busy", bus.busy, 0);
      chk("reset_i_count", bus.i_grant_count, 0);
      step();

      // Single I read
      bus.i_req_valid = 1; bus.i_req_addr = 32'h1234_5640; bus.l2_req_ready = 1;
      at_neg(); chk("t1_i_ready", bus.i_req_ready, 1);
      step(); bus.i_req_valid = 0;
      at_neg();
      chk("t1_l2_valid", bus.l2_req_valid, 1);
      chk("t1_l2_addr", bus.l2_req_addr, 32'h1234_5640);
      chk("t1_l2_src", bus.l2_req_src, 0);
      chk("t1_l2_write", bus.l2_req_write, 0);
      step(); at_neg(); chk("t1_wait_busy", bus.busy, 1);
      step(); bus.l2_resp_valid = 1;
      at_neg(); chk("t1_no_early_resp", bus.i_resp_valid, 0);
      step(); bus.l2_resp_valid = 0;
      at_neg();
      chk("t1_i_resp", bus.i_resp_valid, 1);
      chk("t1_i_count", bus.i_grant_count, 1);
      step(); at_neg(); chk("t1_idle", bus.busy, 0);

      // Simultaneous requests after reset: I first, then D
      do_reset();
      bus.i_req_valid = 1; bus.i_req_addr = 32'hA000_0000;
      bus.d_req_valid = 1; bus.d_req_write = 0; bus.d_req_addr = 32'hB000_0040;
      bus.l2_req_ready = 1; bus.l2_resp_valid = 1;
      at_neg(); chk("t2_i_ready", bus.i_req_ready, 1); chk("t2_d_not_ready", bus.d_req_ready, 0);
      step(); bus.i_req_valid = 0;
      at_neg(); chk("t2_src0", bus.l2_req_src, 0); chk("t2_addr0", bus.l2_req_addr, 32'hA000_0000);
      step(); step(); at_neg(); chk("t2_i_resp", bus.i_resp_valid, 1);
      step(); at_neg(); chk("t2_d_ready", bus.d_req_ready, 1);
      step(); bus.d_req_valid = 0;
      at_neg(); chk("t2_src1", bus.l2_req_src, 1); chk("t2_addr1", bus.l2_req_addr, 32'hB000_0040);
      step(); step(); at_neg();
      chk("t2_d_resp", bus.d_resp_valid, 1);
      chk("t2_i_count", bus.i_grant_count, 1);
      chk("t2_d_count", bus.d_grant_count, 1);
      step();

      // Fairness with both continuously valid
      do_reset();
      bus.i_req_valid = 1; bus.i_req_addr = 32'h0000_1000;
      bus.d_req_valid = 1; bus.d_req_addr = 32'h0000_2000;
      bus.l2_req_ready = 1; bus.l2_resp_valid = 1;
      for (int c = 0; c < 16; c++) begin
         at_neg();
         if (bus.l2_req_valid) src_q.push_back(int'(bus.l2_req_src));
         step();
      end
      bus.i_req_valid = 0; bus.d_req_valid = 0;
      chk("t3_grants", src_q.size(), 4);
      for (int k = 0; k < 4 && k < src_q.size(); k++) chk("t3_alternate", src_q[k], k % 2);
      step(); step(); step(); step();

      // D write with L2 stalling; an I request that drops early never wins
      do_reset();
      bus.d_req_valid = 1; bus.d_req_write = 1; bus.d_req_addr = 32'h0000_0FC0;
      at_neg(); chk("t4_d_ready", bus.d_req_ready, 1);
      step(); bus.d_req_valid = 0; bus.d_req_write = 0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) bus.l2_req_ready = 1;
         bus.i_req_valid = (c == 1);
         bus.i_req_addr  = 32'h0000_3000;
         at_neg();
         chk("t4_l2_valid", bus.l2_req_valid, 1);
         chk("t4_l2_write", bus.l2_req_write, 1);
         chk("t4_l2_addr", bus.l2_req_addr, 32'h0000_0FC0);
         step();
      end
      bus.l2_req_ready = 0; bus.i_req_valid = 0;
      at_neg(); chk("t4_d_resp", bus.d_resp_valid, 1);
      step(); at_neg(); chk("t4_idle", bus.busy, 0); chk("t4_i_count", bus.i_grant_count, 0);
      step();

      // Eviction forwarded while a D read waits for data
      do_reset();
      bus.d_req_valid = 1; bus.d_req_addr = 32'h1234_5600; bus.l2_req_ready = 1;
      step(); bus.d_req_valid = 0;
      step(); bus.l2_evict_valid = 1; bus.l2_evict_addr = 32'h1234_5640;
      at_neg(); chk("t5_evict_not_yet", bus.d_evict_valid, 0);
      step(); bus.l2_evict_valid = 0; bus.l2_evict_addr = '0;
      at_neg();
      chk("t5_evict_valid", bus.d_evict_valid, 1);
      chk("t5_evict_addr", bus.d_evict_addr, 32'h1234_5640);
      chk("t5_busy", bus.busy, 1);
      step(); bus.l2_resp_valid = 1;
      at_neg(); chk("t5_evict_gone", bus.d_evict_valid, 0);
      step(); bus.l2_resp_valid = 0;
      at_neg(); chk("t5_d_resp", bus.d_resp_valid, 1);
      step();

      // Reset while waiting for read data
      do_reset();
      bus.i_req_valid = 1; bus.i_req_addr = 32'h0000_0440; bus.l2_req_ready = 1;
      step(); bus.i_req_valid = 0;
      step(); step(); rst = 1;
      at_neg(); chk("t6_busy_before", bus.busy, 1);
      step(); rst = 0;
      at_neg();
      chk("t6_busy", bus.busy, 0);
      chk("t6_i_count", bus.i_grant_count, 0);
      chk("t6_no_resp", bus.i_resp_valid, 0);
      step(); bus.l2_resp_valid = 1;
      step(); bus.l2_resp_valid = 0;
      at_neg(); chk("t6_stray_resp", bus.i_resp_valid, 0); chk("t6_stray_busy", bus.busy, 0);
      step();

      // Grant counter saturation at CNT_WIDTH=2
      do_reset();
      bus.l2_req_ready = 1; bus.l2_resp_valid = 1;
      for (int k = 0; k < 5; k++) begin
         bus.i_req_valid = 1; bus.i_req_addr = 32'h40 * k;
         at_neg(); chk("t7_ready", bus.i_req_ready, 1);
         step(); bus.i_req_valid = 0;
         step(); step();
         at_neg();
         chk("t7_resp", bus.i_resp_valid, 1);
         chk("t7_count", bus.i_grant_count, sat_exp[k]);
         step();
      end
      bus.l2_resp_valid = 0;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
